// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM states, scancode prefixes, frame length.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Generic show-ahead FIFO with level output; rdata_o always shows mem[rptr].
module ps2_rx_fifo #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          valid_o,
  output logic          full_o,
  output logic [AW:0]   level_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          push_ok, pop_ok;

  assign level_o = wptr_q - rptr_q;
  assign valid_o = (level_o != '0);
  assign full_o  = level_o[AW];
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push while full is still taken.
  assign pop_ok  = pop_i & valid_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop_ok) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: sync + frame FSM + watchdog + show-ahead FIFO.
// Optional scancode decoder on the FIFO output: define PS2_HOST_RX_SCANCODE_EN.
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 1000,
  parameter int TIMEOUT   = 8 * PS2DIV
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               rx_err_parity,
  output logic               rx_err_frame,
  output logic               rx_overflow,
`ifdef PS2_HOST_RX_SCANCODE_EN
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_release,
  output logic               key_strobe,
`endif
  output logic [FIFO_BITS:0] fifo_level
);

  localparam int DATA_BITS = PS2_FRAME_BITS - 3;
  localparam int WDW       = $clog2(TIMEOUT + 1);

  logic       c1_q, c2_q, cp_q, d1_q, d2_q;
  logic       fe, din;
  ps2_state_e state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       acc_q, acc_d, pok_q, pok_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic       push, pop, full;
  logic       perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

  assign fe  = cp_q & ~c2_q;
  assign din = d2_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      c1_q <= 1'b1; c2_q <= 1'b1; cp_q <= 1'b1;
      d1_q <= 1'b1; d2_q <= 1'b1;
    end else begin
      c1_q <= ps2_clk;  c2_q <= c1_q; cp_q <= c2_q;
      d1_q <= ps2_data; d2_q <= d1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    pok_d   = pok_q;
    wd_d    = (state_q == IDLE || fe) ? '0 : wd_q + 1'b1;
    push    = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (state_q != IDLE && wd_q == WDW'(TIMEOUT)) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end else if (fe) begin
      case (state_q)
        IDLE: if (!din) begin
          state_d = DATA;
          bit_d   = '0;
          sh_d    = '0;
          acc_d   = 1'b0;
        end
        DATA: begin
          sh_d  = {din, sh_q[7:1]};
          acc_d = acc_q ^ din;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          pok_d   = acc_q ^ din;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!din)       ferr_d = 1'b1;
          else if (!pok_q) perr_d = 1'b1;
          else            push   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ovf_d = push & full & ~pop;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      acc_q   <= 1'b0;
      pok_q   <= 1'b0;
      wd_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      pok_q   <= pok_d;
      wd_q    <= wd_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rx_err_parity = perr_q;
  assign rx_err_frame  = ferr_q;
  assign rx_overflow   = ovf_q;

  ps2_rx_fifo #(.AW(FIFO_BITS), .DW(8)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (sh_q),
    .pop_i   (pop),
    .rdata_o (rx_data),
    .valid_o (rx_valid),
    .full_o  (full),
    .level_o (fifo_level)
  );

`ifdef PS2_HOST_RX_SCANCODE_EN
  logic       ext_q, rel_q, kext_q, krel_q, kstb_q;
  logic [7:0] kcode_q;
  logic       unused_rdy;

  assign unused_rdy = rx_ready;
  assign pop        = rx_valid;

  // Prefix bytes only arm flags; the next plain byte carries them out.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ext_q <= 1'b0; rel_q <= 1'b0;
      kcode_q <= '0; kext_q <= 1'b0; krel_q <= 1'b0; kstb_q <= 1'b0;
    end else begin
      kstb_q <= 1'b0;
      if (pop) begin
        if (rx_data == PS2_PREFIX_EXT)      ext_q <= 1'b1;
        else if (rx_data == PS2_PREFIX_REL) rel_q <= 1'b1;
        else begin
          kcode_q <= rx_data;
          kext_q  <= ext_q;
          krel_q  <= rel_q;
          kstb_q  <= 1'b1;
          ext_q   <= 1'b0;
          rel_q   <= 1'b0;
        end
      end
    end
  end

  assign key_code    = kcode_q;
  assign key_ext     = kext_q;
  assign key_release = krel_q;
  assign key_strobe  = kstb_q;
`else
  assign pop = rx_valid & rx_ready;
`endif

endmodule
